// File: rtl/riscv_mc_pkg.sv
// Shared types and constants for the multicycle core's memory port.
package riscv_mc_pkg;

    localparam int unsigned XLEN            = 32;
    localparam int unsigned CNT_W           = 8;
    localparam int unsigned TIMEOUT_DEFAULT = 16;

    // RV32I major opcodes used by the main controller
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        FAULT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        ACC_FETCH = 2'd0,
        ACC_LOAD  = 2'd1,
        ACC_STORE = 2'd2
    } access_t;

    // Word accesses only: low two address bits must be zero
    function automatic logic is_aligned(input logic [XLEN-1:0] adr);
        return adr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/mem_port_ctrl_if.sv
// Memory bus between the port controller (master) and the memory (slave).
interface mem_port_ctrl_if;
    import riscv_mc_pkg::*;

    logic            busReq;
    logic            busWrite;
    logic [XLEN-1:0] busAdr;
    logic [XLEN-1:0] busWData;
    logic            busAck;
    logic [XLEN-1:0] busRData;

    modport master (
        output busReq, busWrite, busAdr, busWData,
        input  busAck, busRData
    );

    modport slave (
        input  busReq, busWrite, busAdr, busWData,
        output busAck, busRData
    );
endinterface

// File: rtl/bus_timeout_ctr.sv
// Counts bus wait cycles; flags the cycle whose increment reaches LIMIT.
module bus_timeout_ctr
    import riscv_mc_pkg::*;
#(
    parameter int unsigned LIMIT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic at_limit_c
);

    logic [CNT_W-1:0] cnt;

    // Wait counter: clear has priority over counting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign at_limit_c = en && (cnt == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/mem_port_ctrl.sv
// Memory port controller: serialises fetch/load/store requests onto a
// req/ack bus, holds the main controller with stall, and latches results.
module mem_port_ctrl
    import riscv_mc_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  IRWrite,
    input  logic                  adrSrc,
    input  logic                  memWrite,
    input  logic [XLEN-1:0]       PC,
    input  logic [XLEN-1:0]       result,
    input  logic [XLEN-1:0]       writeData,
    mem_port_ctrl_if.master       bus,
    output logic [XLEN-1:0]       instr,
    output logic [XLEN-1:0]       oldPC,
    output logic [XLEN-1:0]       data,
    output logic                  stall,
    output logic                  err
);

    state_t          state, state_next;
    access_t         kind;
    logic [XLEN-1:0] address_c;
    logic            req_c, start_c, wait_c, limit_c;
    logic [XLEN-1:0] bus_adr, bus_wdata;
    logic            bus_req, bus_write;

    assign bus.busReq   = bus_req;
    assign bus.busWrite = bus_write;
    assign bus.busAdr   = bus_adr;
    assign bus.busWData = bus_wdata;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state, start strobe, wait enable and stall; a held reset masks requests
    always_comb begin
        state_next = state;
        start_c    = 1'b0;
        wait_c     = 1'b0;
        stall      = 1'b0;
        address_c  = adrSrc ? result : PC;
        req_c      = (adrSrc | IRWrite) & ~rst;
        case (state)
            IDLE: begin
                if (req_c) begin
                    if (is_aligned(address_c)) begin
                        start_c    = 1'b1;
                        stall      = 1'b1;
                        state_next = BUSY;
                    end else begin
                        state_next = FAULT;
                    end
                end
            end
            BUSY: begin
                if (bus.busAck) begin
                    state_next = IDLE;
                end else begin
                    stall  = 1'b1;
                    wait_c = 1'b1;
                    if (limit_c) state_next = FAULT;
                end
            end
            FAULT: begin
                stall = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    bus_timeout_ctr #(.LIMIT(TIMEOUT)) u_timeout (
        .clk        (clk),
        .rst        (rst),
        .clr        (start_c),
        .en         (wait_c),
        .at_limit_c (limit_c)
    );

    // Bus request registers, access latch and result capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_req   <= 1'b0;
            bus_write <= 1'b0;
            bus_adr   <= '0;
            bus_wdata <= '0;
            kind      <= ACC_FETCH;
            instr     <= '0;
            oldPC     <= '0;
            data      <= '0;
            err       <= 1'b0;
        end else begin
            bus_req <= (state_next == BUSY);
            err     <= err | (state_next == FAULT);
            if (start_c) begin
                bus_adr   <= address_c;
                bus_write <= adrSrc & memWrite;
                bus_wdata <= writeData;
                kind      <= adrSrc ? (memWrite ? ACC_STORE : ACC_LOAD) : ACC_FETCH;
                if (!adrSrc) oldPC <= PC;
            end
            if (state == BUSY && bus.busAck) begin
                case (kind)
                    ACC_FETCH: instr <= bus.busRData;
                    ACC_LOAD:  data  <= bus.busRData;
                    default:   ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Directed bench for mem_port_ctrl: fetch, load/store, priority, timeout,
// misalignment and asynchronous reset.
module tb_mem_port_ctrl;
    import riscv_mc_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        IRWrite, adrSrc, memWrite;
    logic [31:0] PC, result, writeData;
    logic [31:0] instr, oldPC, data;
    logic        stall, err;

    int n_checks = 0;
    int n_errors = 0;

    int          stalls;
    logic        cap_req, cap_write;
    logic [31:0] cap_adr, cap_wdata;

    mem_port_ctrl_if bus_if ();

    mem_port_ctrl #(.TIMEOUT(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .IRWrite   (IRWrite),
        .adrSrc    (adrSrc),
        .memWrite  (memWrite),
        .PC        (PC),
        .result    (result),
        .writeData (writeData),
        .bus       (bus_if),
        .instr     (instr),
        .oldPC     (oldPC),
        .data      (data),
        .stall     (stall),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Single comparison point for the whole bench
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        IRWrite   = 1'b0;
        adrSrc    = 1'b0;
        memWrite  = 1'b0;
        PC        = '0;
        result    = '0;
        writeData = '0;
        bus_if.busAck   = 1'b0;
        bus_if.busRData = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One complete access; memory acks after nwait BUSY cycles without ack
    task automatic access(input logic a_src, input logic irw, input logic mw,
                          input logic [31:0] pc_v, input logic [31:0] res_v,
                          input logic [31:0] wd_v, input logic [31:0] rd_v,
                          input int nwait);
        @(negedge clk);
        adrSrc = a_src; IRWrite = irw; memWrite = mw;
        PC = pc_v; result = res_v; writeData = wd_v;
        stalls = 0;
        #1 if (stall) stalls++;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < nwait; i++) begin
            #1 if (stall) stalls++;
            @(posedge clk);
            @(negedge clk);
        end
        bus_if.busAck   = 1'b1;
        bus_if.busRData = rd_v;
        #1 if (stall) stalls++;
        cap_req   = bus_if.busReq;
        cap_write = bus_if.busWrite;
        cap_adr   = bus_if.busAdr;
        cap_wdata = bus_if.busWData;
        @(posedge clk);
        @(negedge clk);
        clear_inputs();
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        #1;
        check("rst_busReq", 32'(bus_if.busReq), 32'd0);
        check("rst_stall",  32'(stall),         32'd0);
        check("rst_err",    32'(err),           32'd0);
        check("rst_instr",  instr,              32'd0);
        check("rst_busAdr", bus_if.busAdr,      32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Fetch with three wait cycles
        access(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 32'h0, 32'h00500093, 3);
        check("fetch_stalls",  32'(stalls),     32'd4);
        check("fetch_req",     32'(cap_req),    32'd1);
        check("fetch_adr",     cap_adr,         32'h10);
        check("fetch_instr",   instr,           32'h00500093);
        check("fetch_oldPC",   oldPC,           32'h10);
        check("fetch_idle_req",32'(bus_if.busReq), 32'd0);
        check("fetch_idle_stall", 32'(stall),   32'd0);

        // Load then store
        access(1'b1, 1'b0, 1'b0, 32'h0, 32'h40, 32'h0, 32'hDEADBEEF, 0);
        check("load_stalls", 32'(stalls),  32'd1);
        check("load_adr",    cap_adr,      32'h40);
        check("load_write",  32'(cap_write), 32'd0);
        check("load_data",   data,         32'hDEADBEEF);
        access(1'b1, 1'b0, 1'b1, 32'h0, 32'h44, 32'h12345678, 32'hCAFEF00D, 1);
        check("store_write", 32'(cap_write), 32'd1);
        check("store_wdata", cap_wdata,    32'h12345678);
        check("store_adr",   cap_adr,      32'h44);
        check("store_data",  data,         32'hDEADBEEF);
        check("store_instr", instr,        32'h00500093);

        // Ack while idle is ignored
        @(negedge clk);
        bus_if.busAck = 1'b1; bus_if.busRData = 32'h99999999;
        @(negedge clk);
        bus_if.busAck = 1'b0;
        #1;
        check("idle_ack_instr", instr, 32'h00500093);
        check("idle_ack_data",  data,  32'hDEADBEEF);
        check("idle_ack_req",   32'(bus_if.busReq), 32'd0);

        // memWrite without adrSrc is a plain fetch
        access(1'b0, 1'b1, 1'b1, 32'h20, 32'h0, 32'h55, 32'h00000013, 0);
        check("mw_fetch_write", 32'(cap_write), 32'd0);
        check("mw_fetch_instr", instr,          32'h00000013);
        check("mw_fetch_oldPC", oldPC,          32'h20);

        // adrSrc wins over IRWrite
        access(1'b1, 1'b1, 1'b0, 32'h30, 32'h80, 32'h0, 32'h00000777, 0);
        check("prio_adr",   cap_adr, 32'h80);
        check("prio_instr", instr,   32'h00000013);
        check("prio_oldPC", oldPC,   32'h20);
        check("prio_data",  data,    32'h00000777);

        // Reset in the second BUSY cycle
        @(negedge clk);
        PC = 32'h100; IRWrite = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_req",   32'(bus_if.busReq), 32'd0);
        check("midrst_stall", 32'(stall),         32'd0);
        check("midrst_err",   32'(err),           32'd0);
        check("midrst_instr", instr,              32'd0);
        check("midrst_adr",   bus_if.busAdr,      32'd0);
        check("midrst_data",  data,               32'd0);
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        access(1'b0, 1'b1, 1'b0, 32'h200, 32'h0, 32'h0, 32'h00000ABC, 1);
        check("postrst_stalls", 32'(stalls), 32'd2);
        check("postrst_instr",  instr,       32'h00000ABC);
        check("postrst_oldPC",  oldPC,       32'h200);

        // Timeout after 16 wait cycles
        @(negedge clk);
        PC = 32'h300; IRWrite = 1'b1;
        @(posedge clk);
        repeat (15) @(posedge clk);
        @(negedge clk);
        #1;
        check("to_last_req", 32'(bus_if.busReq), 32'd1);
        check("to_last_err", 32'(err),           32'd0);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("to_err",   32'(err),           32'd1);
        check("to_stall", 32'(stall),         32'd1);
        check("to_req",   32'(bus_if.busReq), 32'd0);
        bus_if.busAck = 1'b1; bus_if.busRData = 32'hFFFFFFFF;
        @(posedge clk);
        @(negedge clk);
        bus_if.busAck = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("to_late_instr", instr,              32'h00000ABC);
        check("to_late_err",   32'(err),           32'd1);
        check("to_late_stall", 32'(stall),         32'd1);
        check("to_late_req",   32'(bus_if.busReq), 32'd0);
        check("to_oldPC",      oldPC,              32'h300);

        // Misaligned data address
        do_reset();
        @(negedge clk);
        adrSrc = 1'b1; result = 32'h42;
        #1;
        check("mis_req0", 32'(bus_if.busReq), 32'd0);
        @(posedge clk);
        @(negedge clk);
        adrSrc = 1'b0;
        #1;
        check("mis_req1",  32'(bus_if.busReq), 32'd0);
        check("mis_err",   32'(err),           32'd1);
        check("mis_stall", 32'(stall),         32'd1);
        check("mis_adr",   bus_if.busAdr,      32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
